// File: rtl/prf_wb_pkg.sv
// Shared constants and helpers for the PRF write-back unit.
// The request struct is declared in the top module because its widths are module parameters.
package prf_wb_pkg;

    localparam int NUM_SRC    = 2;
    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_sel_e;

    // Round-robin: after a grant the other source gets priority.
    function automatic src_sel_e rr_next(input src_sel_e granted);
        return (granted == SRC0) ? SRC1 : SRC0;
    endfunction

endpackage

// File: rtl/prf_writeback_unit_if.sv
// Bus bundle of the write-back unit: two producer request channels plus the PRF write port.
// The master modport is the write-back unit itself; slave is the producers/PRF side.
interface prf_writeback_unit_if #(
    parameter int DIR_WIDTH  = 10,
    parameter int DATA_WIDTH = 256
);
    // Handshake: a transfer happens on a rising edge with valid && ready. ready is
    // registered and never depends on valid; dir/data must stay stable while valid && !ready.
    logic                  src0_valid;
    logic                  src0_ready;
    logic [DIR_WIDTH-1:0]  src0_dir;
    logic [DATA_WIDTH-1:0] src0_data;

    logic                  src1_valid;
    logic                  src1_ready;
    logic [DIR_WIDTH-1:0]  src1_dir;
    logic [DATA_WIDTH-1:0] src1_data;

    logic                  write_en;
    logic [DIR_WIDTH-1:0]  write_dir;
    logic [DATA_WIDTH-1:0] write_data;

    modport master (
        input  src0_valid, src0_dir, src0_data,
        input  src1_valid, src1_dir, src1_data,
        output src0_ready, src1_ready,
        output write_en, write_dir, write_data
    );

    modport slave (
        output src0_valid, src0_dir, src0_data,
        output src1_valid, src1_dir, src1_data,
        input  src0_ready, src1_ready,
        input  write_en, write_dir, write_data
    );

endinterface

// File: rtl/prf_wb_fifo.sv
// Small in-order FIFO buffering one producer's write requests.
// not_full is registered from the next occupancy so ready never loops back through valid.
module prf_wb_fifo
    import prf_wb_pkg::*;
#(
    parameter int WIDTH = 266
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             not_full,
    output logic [OCC_W-1:0] occ
);

    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ_next;

    always_comb begin
        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + 1'b1;
        end else if (pop && !push) begin
            occ_next = occ - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            not_full <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occ      <= occ_next;
            not_full <= (occ_next != FULL_OCC);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (occ == '0);

endmodule

// File: rtl/prf_writeback_unit.sv
// Write-side initiator for the PRF: two buffered producers, round-robin arbitration,
// registered single write port, register-0 filtering, committed-write counter and idle flag.
module prf_writeback_unit
    import prf_wb_pkg::*;
#(
    parameter int DIR_WIDTH  = 10,
    parameter int DATA_WIDTH = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 arst_n,
    prf_writeback_unit_if.master bus,
    output logic [CNT_WIDTH-1:0] wb_count,
    output logic                 idle
);

    typedef struct packed {
        logic [DIR_WIDTH-1:0]  dir;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

    localparam int REQ_W = $bits(wb_req_t);

    wb_req_t          push_req0, push_req1;
    wb_req_t          head0, head1;
    wb_req_t          grant_req;
    logic             push0, push1;
    logic             pop0, pop1;
    logic             empty0, empty1;
    logic             rdy0, rdy1;
    logic [OCC_W-1:0] occ0, occ1;

    logic             grant_vld;
    src_sel_e         grant_sel;
    src_sel_e         rr_ptr;

    logic                  write_en_q;
    logic [DIR_WIDTH-1:0]  write_dir_q;
    logic [DATA_WIDTH-1:0] write_data_q;

    assign push_req0 = '{dir: bus.src0_dir, data: bus.src0_data};
    assign push_req1 = '{dir: bus.src1_dir, data: bus.src1_data};
    assign push0     = bus.src0_valid && rdy0;
    assign push1     = bus.src1_valid && rdy1;

    prf_wb_fifo #(.WIDTH(REQ_W)) u_fifo0 (
        .clk       (clk),
        .arst_n    (arst_n),
        .push      (push0),
        .push_data (push_req0),
        .pop       (pop0),
        .head      (head0),
        .empty     (empty0),
        .not_full  (rdy0),
        .occ       (occ0)
    );

    prf_wb_fifo #(.WIDTH(REQ_W)) u_fifo1 (
        .clk       (clk),
        .arst_n    (arst_n),
        .push      (push1),
        .push_data (push_req1),
        .pop       (pop1),
        .head      (head1),
        .empty     (empty1),
        .not_full  (rdy1),
        .occ       (occ1)
    );

    // The pointer only breaks ties; a lone candidate always wins.
    always_comb begin
        grant_vld = !empty0 || !empty1;
        grant_sel = SRC0;
        if (!empty0 && !empty1) begin
            grant_sel = rr_ptr;
        end else if (!empty1) begin
            grant_sel = SRC1;
        end
    end

    assign pop0      = grant_vld && (grant_sel == SRC0);
    assign pop1      = grant_vld && (grant_sel == SRC1);
    assign grant_req = (grant_sel == SRC1) ? head1 : head0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            write_en_q   <= 1'b0;
            write_dir_q  <= '0;
            write_data_q <= '0;
            wb_count     <= '0;
            rr_ptr       <= SRC0;
        end else begin
            if (grant_vld) begin
                // Register 0 is consumed like any entry but never reaches the PRF.
                write_en_q   <= (grant_req.dir != '0);
                write_dir_q  <= grant_req.dir;
                write_data_q <= grant_req.data;
                rr_ptr       <= rr_next(grant_sel);
                if (grant_req.dir != '0) begin
                    wb_count <= wb_count + 1'b1;
                end
            end else begin
                write_en_q <= 1'b0;
            end
        end
    end

    assign bus.src0_ready = rdy0;
    assign bus.src1_ready = rdy1;
    assign bus.write_en   = write_en_q;
    assign bus.write_dir  = write_dir_q;
    assign bus.write_data = write_data_q;

    assign idle = (occ0 == '0) && (occ1 == '0) && !write_en_q;

endmodule
